regfile_dump: RTL and testbench

Debug reader that drives the register file's two read ports and streams every register out as (address, data) beats over a valid/ready interface. It sits beside the register file in the Lab-4 CPU top level. While it runs, it asserts a write-block so the top level forces we3 low; the register file only updates its read outputs when we3 is low. The block is used by the testbench and display logic to dump architectural state after a program halts.

---
 rtl/regfile_dump_if.sv | 24 ++
 rtl/regfile_dump.sv | 109 ++++++++++
 tb/tb_regfile_dump.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Register-file read port plus the (address, data) beat stream of the dump reader.
interface regfile_dump_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] ad1;
  logic [ADDRESS_WIDTH-1:0] ad2;
  logic [DATA_WIDTH-1:0]    rd1;
  logic [DATA_WIDTH-1:0]    rd2;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDRESS_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0]    out_data;

  modport master (
    output ad1, ad2, out_valid, out_addr, out_data,
    input  rd1, rd2, out_ready
  );

  modport slave (
    input  ad1, ad2, out_valid, out_addr, out_data,
    output rd1, rd2, out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Streams every register as (address, data) beats, reading two registers per pair.
// Optional REGFILE_DUMP_SKIP_ZERO_EN suppresses the beat for hardwired register 0.
module regfile_dump #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rf_we_block,
  regfile_dump_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CAPTURE, S_SEND_LO, S_SEND_HI, S_DONE
  } state_t;

  // One extra bit so idx+2 reaches NUM_REGS without wrapping at 2**ADDRESS_WIDTH
  localparam logic [ADDRESS_WIDTH:0] LAST_P2 = (ADDRESS_WIDTH+1)'(NUM_REGS);

  state_t                  r_state, w_next;
  logic [ADDRESS_WIDTH:0]  r_idx, w_idx_next;
  logic [ADDRESS_WIDTH:0]  w_idx_p1, w_idx_p2;
  logic [DATA_WIDTH-1:0]   r_lo, r_hi;
  logic                    w_hs;

  assign w_idx_p1 = r_idx + (ADDRESS_WIDTH+1)'(1);
  assign w_idx_p2 = r_idx + (ADDRESS_WIDTH+1)'(2);
  assign w_hs     = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      if (r_state == S_CAPTURE) begin
        r_lo <= bus.rd1;
        r_hi <= bus.rd2;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_idx_next    = r_idx;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    bus.ad1       = '0;
    bus.ad2       = '0;
    bus.out_valid = 1'b0;
    bus.out_addr  = '0;
    bus.out_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_next = '0;
          w_next     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.ad1 = r_idx[ADDRESS_WIDTH-1:0];
        bus.ad2 = w_idx_p1[ADDRESS_WIDTH-1:0];
        w_next  = S_CAPTURE;
      end
      S_CAPTURE: begin
        bus.ad1 = r_idx[ADDRESS_WIDTH-1:0];
        bus.ad2 = w_idx_p1[ADDRESS_WIDTH-1:0];
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
        w_next  = (r_idx == '0) ? S_SEND_HI : S_SEND_LO;
`else
        w_next  = S_SEND_LO;
`endif
      end
      S_SEND_LO: begin
        bus.out_valid = 1'b1;
        bus.out_addr  = r_idx[ADDRESS_WIDTH-1:0];
        bus.out_data  = r_lo;
        if (w_hs) w_next = S_SEND_HI;
      end
      S_SEND_HI: begin
        bus.out_valid = 1'b1;
        bus.out_addr  = w_idx_p1[ADDRESS_WIDTH-1:0];
        bus.out_data  = r_hi;
        if (w_hs) begin
          if (w_idx_p2 == LAST_P2) begin
            w_next = S_DONE;
          end else begin
            w_idx_next = w_idx_p2;
            w_next     = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    rf_we_block = busy;
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: register-file model, random stalls and CPU writes.
module tb_regfile_dump;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, rf_we_block;

  regfile_dump_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_dump #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rf_we_block(rf_we_block), .bus(bus)
  );

  always #5 clk = ~clk;

  // Register-file model: reg 0 reads as zero, read outputs only update when we3 is low
  logic [DW-1:0] regs [N];
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_wa = '0;
  logic [DW-1:0] cpu_wd = '0;
  logic          we3;
  assign we3 = cpu_we & ~rf_we_block;

  always @(posedge clk) begin
    if (we3) begin
      if (cpu_wa != '0) regs[cpu_wa] <= cpu_wd;
    end else begin
      bus.rd1 <= (bus.ad1 == '0) ? '0 : regs[bus.ad1];
      bus.rd2 <= (bus.ad2 == '0) ? '0 : regs[bus.ad2];
    end
  end

  // Environment: preload reg[i]=i*0x11, then drive ready pattern and optional CPU writes
  int rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  bit cpu_rand = 1'b0;
  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b1;
    for (int i = 1; i < N; i++) begin
      @(posedge clk); #1;
      cpu_we = 1'b1; cpu_wa = AW'(i); cpu_wd = DW'(i * 32'h11);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
        2:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b1;
      endcase
      k++;
      if (cpu_rand) begin
        cpu_we = 1'b1;
        cpu_wa = AW'($urandom_range(1, N - 1));
        cpu_wd = $urandom;
      end else begin
        cpu_we = 1'b0;
      end
    end
  end

  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: a dump lists every register in index order with its contents at start
  task automatic push_expected();
    beat_t b;
    for (int i = 0; i < N; i++) begin
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
      if (i == 0) continue;
`endif
      b.a = AW'(i);
      b.d = (i == 0) ? '0 : regs[i];
      exp_q.push_back(b);
    end
  endtask

  // Issues start; runs until done or a cycle budget. Optionally re-pulses start
  // mid-dump, or resets during the SEND_HI beat of pair idx=8 (addr 17).
  task automatic run_dump(input bit restart_mid, input bit abort17,
                          output int lat_valid, output int lat_done);
    int n;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    push_expected();
    n = 1; lat_valid = -1; lat_done = -1;
    while (n < 600) begin
      if (bus.out_valid && lat_valid < 0) lat_valid = n;
      if (done) begin lat_done = n; break; end
      if (abort17 && bus.out_valid && bus.out_addr == AW'(17)) begin
        rst = 1'b1; #1;
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_we_block", 64'(rf_we_block), 64'd0);
        chk("abort_addr", 64'(bus.out_addr), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        return;
      end
      start = restart_mid && (n >= 18) && (n <= 26);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (lat_done < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_dump(input int want_done_cnt);
    repeat (3) @(posedge clk);
    #1;
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(want_done_cnt));
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int lv, ld, dc;
`ifdef REGFILE_DUMP_SKIP_ZERO_EN
    localparam int DONE_LAT = 64;
`else
    localparam int DONE_LAT = 65;
`endif
    fork
      begin : monitor
        bit    stall;
        beat_t held, e;
        stall = 1'b0;
        held  = '0;
        forever begin
          @(negedge clk);
          if (rst) begin stall = 1'b0; continue; end
          chk("we_block_eq_busy", 64'(rf_we_block), 64'(busy));
          if (stall) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_addr", 64'(bus.out_addr), 64'(held.a));
            chk("stall_data", 64'(bus.out_data), 64'(held.d));
          end
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_beat_addr", 64'(bus.out_addr), 64'hFFFF);
            end else begin
              e = exp_q.pop_front();
              chk("beat_addr", 64'(bus.out_addr), 64'(e.a));
              chk("beat_data", 64'(bus.out_data), 64'(e.d));
            end
          end
          stall  = bus.out_valid && !bus.out_ready;
          held.a = bus.out_addr;
          held.d = bus.out_data;
          if (done) done_cnt++;
        end
      end
    join_none

    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we_block", 64'(rf_we_block), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ad1", 64'(bus.ad1), 64'd0);
    chk("rst_ad2", 64'(bus.ad2), 64'd0);
    chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);

    // Preloaded dump with ready tied high; latency of first beat and of done
    rdy_mode = 0;
    run_dump(1'b0, 1'b0, lv, ld);
    chk("first_valid_latency", 64'(lv), 64'd3);
    chk("done_latency", 64'(ld), 64'(DONE_LAT));
    finish_dump(1);

    // Stalls with a 1,0,0,1 ready pattern
    rdy_mode = 1;
    run_dump(1'b0, 1'b0, lv, ld);
    finish_dump(2);

    // start re-asserted while busy is ignored
    rdy_mode = 0;
    run_dump(1'b1, 1'b0, lv, ld);
    finish_dump(3);
    repeat (10) @(posedge clk);
    #1;
    chk("no_restart_busy", 64'(busy), 64'd0);
    chk("no_restart_done", 64'(done_cnt), 64'd3);

    // Reset mid-dump: no done pulse, then a fresh complete dump
    dc = done_cnt;
    run_dump(1'b0, 1'b1, lv, ld);
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    chk("abort_idle", 64'(busy), 64'd0);
    run_dump(1'b0, 1'b0, lv, ld);
    chk("post_abort_first_valid", 64'(lv), 64'd3);
    finish_dump(dc + 1);

    // CPU writes throughout with random stalls: dumped values are the pre-dump contents
    for (int r = 0; r < 3; r++) begin
      rdy_mode = 2;
      cpu_rand = 1'b1;
      dc = done_cnt;
      run_dump(1'b0, 1'b0, lv, ld);
      finish_dump(dc + 1);
      cpu_rand = 1'b0;
      repeat (5) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
